// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera capture path and the
// ping-pong buffer reader that consumes its frames.
package cam_pkg;

    localparam int IMG_W        = 480;
    localparam int IMG_H        = 272;
    localparam int TOTAL_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W       = 17;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CAPT = 2'b01,
        S_DROP = 2'b10
    } state_t;

endpackage

// File: rtl/cam_pix_pack.sv
// Byte-pair packer: latches the high byte, then issues one registered
// RGB565 write (enable, address, data) one cycle after the low byte.
module cam_pix_pack
    import cam_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_W
) (
    input  logic                 iClk,
    input  logic                 wRst,
    input  logic                 clr,
    input  logic                 byte_vld,
    input  logic [7:0]           byte_dt,
    input  logic                 wr_ok,
    input  logic [ADDR_BITS-1:0] pix_addr,
    output logic                 phase,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [15:0]          wr_dt
);

    logic                 phase_r;
    logic [7:0]           hi_r;
    logic                 wr_en_r;
    logic [ADDR_BITS-1:0] wr_addr_r;
    logic [15:0]          wr_dt_r;
    logic                 pix_wr_s;

    // A pixel is written when the low byte arrives and the frame has room.
    always_comb begin
        pix_wr_s = byte_vld & phase_r & wr_ok;
    end

    // Byte phase, high-byte latch and the one-cycle write register.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            phase_r   <= 1'b0;
            hi_r      <= 8'd0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_dt_r   <= 16'd0;
        end else begin
            wr_en_r <= pix_wr_s;
            if (pix_wr_s) begin
                wr_addr_r <= pix_addr;
                wr_dt_r   <= {hi_r, byte_dt};
            end
            if (clr) begin
                phase_r <= 1'b0;
            end else if (byte_vld) begin
                if (!phase_r) begin
                    hi_r <= byte_dt;
                end
                phase_r <= ~phase_r;
            end
        end
    end

    assign phase   = phase_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_dt   = wr_dt_r;

endmodule

// File: rtl/cam_buf_wr.sv
// Camera capture stage: packs the byte stream into RGB565 pixels, writes
// whole frames into ping-pong buffer 0/1, and maintains the per-buffer full
// flags. Malformed frames are discarded; frames aimed at a full buffer are
// skipped.
module cam_buf_wr #(
    parameter int IMG_W  = cam_pkg::IMG_W,
    parameter int IMG_H  = cam_pkg::IMG_H,
    parameter int ADDR_W = cam_pkg::ADDR_W
) (
    input  logic              iClk,
    input  logic              wRst,
    input  logic              iCamVsync,
    input  logic              iCamHref,
    input  logic              iCamByteVld,
    input  logic [7:0]        iCamData,
    input  logic              iBuf0Rel,
    input  logic              iBuf1Rel,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [15:0]       oWrDt,
    output logic              oBufSel,
    output logic              oBuf0Full,
    output logic              oBuf1Full,
    output logic              oFrmDone,
    output logic              oFrmErr,
    output logic              oFrmDrop
);

    // Column and row counters saturate one past nominal so that overlong
    // lines or frames can never wrap back onto a legal value.
    localparam int                COL_W      = $clog2(IMG_W + 2);
    localparam int                ROW_W      = $clog2(IMG_H + 2);
    localparam logic [ADDR_W-1:0] PIX_LAST_L = ADDR_W'(IMG_W * IMG_H);
    localparam logic [COL_W-1:0]  COL_END_L  = COL_W'(IMG_W);
    localparam logic [COL_W-1:0]  COL_SAT_L  = COL_W'(IMG_W + 1);
    localparam logic [ROW_W-1:0]  ROW_END_L  = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0]  ROW_SAT_L  = ROW_W'(IMG_H + 1);

    cam_pkg::state_t   state_r;
    logic              vsync_d_r;
    logic              href_d_r;
    logic              next_sel_r;
    logic              buf_sel_r;
    logic              err_r;
    logic              buf0_full_r;
    logic              buf1_full_r;
    logic              done_r;
    logic              ferr_r;
    logic              drop_r;
    logic [ADDR_W-1:0] pix_cnt_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;

    logic              vs_fall_s;
    logic              vs_rise_s;
    logic              hr_fall_s;
    logic              byte_s;
    logic              phase_s;
    logic              wr_ok_s;
    logic              pix_wr_s;
    logic              pix_ovf_s;
    logic              target_full_s;
    logic              capt_entry_s;
    logic              line_end_s;
    logic              line_bad_s;
    logic              pack_clr_s;
    logic              err_next_s;
    logic [ROW_W-1:0]  row_next_s;
    logic              commit_s;
    logic              commit_ev_s;
    logic              set0_s;
    logic              set1_s;

    // Sync edges, byte qualification and overflow guard.
    always_comb begin
        vs_fall_s     = vsync_d_r & ~iCamVsync;
        vs_rise_s     = ~vsync_d_r & iCamVsync;
        hr_fall_s     = href_d_r & ~iCamHref;
        byte_s        = (state_r == cam_pkg::S_CAPT) & iCamByteVld & iCamHref;
        wr_ok_s       = (pix_cnt_r != PIX_LAST_L);
        pix_wr_s      = byte_s & phase_s & wr_ok_s;
        pix_ovf_s     = byte_s & phase_s & ~wr_ok_s;
        target_full_s = next_sel_r ? buf1_full_r : buf0_full_r;
        capt_entry_s  = (state_r == cam_pkg::S_IDLE) & vs_fall_s & ~target_full_s;
        line_end_s    = (state_r == cam_pkg::S_CAPT) & hr_fall_s;
        line_bad_s    = (col_r != COL_END_L) | phase_s;
        pack_clr_s    = capt_entry_s | line_end_s;
    end

    // Error and row state after this cycle's byte and line end, so that a
    // VSYNC rise in the same cycle judges the frame on its final contents.
    always_comb begin
        err_next_s = err_r | pix_ovf_s;
        row_next_s = row_r;
        if (line_end_s) begin
            err_next_s = err_r | pix_ovf_s | line_bad_s;
            if (row_r == ROW_SAT_L) begin
                row_next_s = row_r;
            end else begin
                row_next_s = row_r + ROW_W'(1);
            end
        end else begin
            row_next_s = row_r;
        end
        commit_s    = (row_next_s == ROW_END_L) & ~err_next_s;
        commit_ev_s = (state_r == cam_pkg::S_CAPT) & vs_rise_s & commit_s;
        set0_s      = commit_ev_s & ~buf_sel_r;
        set1_s      = commit_ev_s & buf_sel_r;
    end

    // Delayed sync copies for edge detection.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= iCamVsync;
            href_d_r  <= iCamHref;
        end
    end

    // Capture FSM with frame counters and the done/error/drop pulses.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            state_r    <= cam_pkg::S_IDLE;
            next_sel_r <= 1'b0;
            buf_sel_r  <= 1'b0;
            err_r      <= 1'b0;
            pix_cnt_r  <= '0;
            col_r      <= '0;
            row_r      <= '0;
            done_r     <= 1'b0;
            ferr_r     <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            ferr_r <= 1'b0;
            drop_r <= 1'b0;
            case (state_r)
                cam_pkg::S_IDLE: begin
                    if (vs_fall_s) begin
                        if (target_full_s) begin
                            state_r <= cam_pkg::S_DROP;
                        end else begin
                            state_r   <= cam_pkg::S_CAPT;
                            buf_sel_r <= next_sel_r;
                            pix_cnt_r <= '0;
                            col_r     <= '0;
                            row_r     <= '0;
                            err_r     <= 1'b0;
                        end
                    end
                end
                cam_pkg::S_CAPT: begin
                    if (pix_wr_s) begin
                        pix_cnt_r <= pix_cnt_r + ADDR_W'(1);
                        if (col_r != COL_SAT_L) begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                    if (line_end_s) begin
                        col_r <= '0;
                    end
                    row_r <= row_next_s;
                    err_r <= err_next_s;
                    if (vs_rise_s) begin
                        state_r <= cam_pkg::S_IDLE;
                        if (commit_s) begin
                            done_r     <= 1'b1;
                            next_sel_r <= ~next_sel_r;
                        end else begin
                            ferr_r <= 1'b1;
                        end
                    end
                end
                cam_pkg::S_DROP: begin
                    if (vs_rise_s) begin
                        drop_r  <= 1'b1;
                        state_r <= cam_pkg::S_IDLE;
                    end
                end
                default: begin
                    state_r <= cam_pkg::S_IDLE;
                end
            endcase
        end
    end

    // Buffer full flags: commit sets, reader release clears, set wins.
    always_ff @(posedge iClk) begin
        if (wRst) begin
            buf0_full_r <= 1'b0;
            buf1_full_r <= 1'b0;
        end else begin
            if (set0_s) begin
                buf0_full_r <= 1'b1;
            end else if (iBuf0Rel) begin
                buf0_full_r <= 1'b0;
            end
            if (set1_s) begin
                buf1_full_r <= 1'b1;
            end else if (iBuf1Rel) begin
                buf1_full_r <= 1'b0;
            end
        end
    end

    cam_pix_pack #(
        .ADDR_BITS (ADDR_W)
    ) u_pack (
        .iClk     (iClk),
        .wRst     (wRst),
        .clr      (pack_clr_s),
        .byte_vld (byte_s),
        .byte_dt  (iCamData),
        .wr_ok    (wr_ok_s),
        .pix_addr (pix_cnt_r),
        .phase    (phase_s),
        .wr_en    (oWrEn),
        .wr_addr  (oWrAddr),
        .wr_dt    (oWrDt)
    );

    assign oBufSel   = buf_sel_r;
    assign oBuf0Full = buf0_full_r;
    assign oBuf1Full = buf1_full_r;
    assign oFrmDone  = done_r;
    assign oFrmErr   = ferr_r;
    assign oFrmDrop  = drop_r;

endmodule

// File: doc/cam_buf_wr.md
Name: cam_buf_wr

Overview:
Capture stage upstream of the ping-pong image-buffer reader. Takes the camera's byte stream (VSYNC/HREF/8-bit data, already synchronised into iClk with a byte strobe) and packs byte pairs into RGB565 pixels. Writes each 480x272 frame into buffer 0 or 1 and raises per-buffer full flags that the reader edge-detects. Frames that are malformed, or that arrive while the target buffer is still full, are discarded and reported.

Parameters:
IMG_W, 480, active pixels per line
IMG_H, 272, active lines per frame
ADDR_W, 17, buffer address width (IMG_W*IMG_H = 130560 must be < 2^ADDR_W)

Ports:
iClk  in  1  system clock
wRst  in  1  synchronous reset, active-high
iCamVsync  in  1  frame sync; high = vertical blanking
iCamHref  in  1  line valid
iCamByteVld  in  1  one-cycle strobe: iCamData valid this cycle
iCamData  in  8  pixel byte; high byte first
iBuf0Rel  in  1  one-cycle pulse from reader: buffer 0 consumed
iBuf1Rel  in  1  one-cycle pulse from reader: buffer 1 consumed
oWrEn  out  1  buffer write strobe
oWrAddr  out  ADDR_W  pixel address, 0..IMG_W*IMG_H-1
oWrDt  out  16  pixel {hi,lo}
oBufSel  out  1  buffer currently being written
oBuf0Full  out  1  level; buffer 0 holds a complete frame
oBuf1Full  out  1  level; buffer 1 holds a complete frame
oFrmDone  out  1  one-cycle pulse: frame committed
oFrmErr  out  1  one-cycle pulse: frame discarded (geometry error)
oFrmDrop  out  1  one-cycle pulse: frame skipped (target buffer full)

Behaviour:
- Reset (wRst=1 at a clock edge): every output is 0; state S_IDLE; rNextSel=0; all counters and the byte phase are 0. Reset mid-frame abandons that frame. Capture resumes at the next VSYNC falling edge.
- Edge detect: rVsyncD and rHrefD registered copies. vs_fall = rVsyncD & !iCamVsync; vs_rise = !rVsyncD & iCamVsync; hr_fall = rHrefD & !iCamHref.
- S_IDLE: on vs_fall, target = rNextSel.
  - If the target's full flag is 1, go to S_DROP.
  - Otherwise go to S_CAPT with oBufSel=target and pixel count, column, row, byte phase and error flag all cleared.
- S_CAPT, on a byte (iCamByteVld & iCamHref); bytes with href low are ignored:
  - Phase 0: latch the high byte and set phase to 1.
  - Phase 1: oWrEn=1 on the next cycle, with oWrDt={hi,iCamData} and oWrAddr=pixel count. Then increment pixel count and column, and set phase to 0.
  - Write latency is 1 cycle after the second byte. oWrEn is otherwise 0.
- S_CAPT, pixel overflow: a would-be pixel when count == IMG_W*IMG_H is suppressed (no write) and sets the error flag.
- S_CAPT, on hr_fall: if column != IMG_W or phase != 0, set the error flag. Row increments (saturating at IMG_H+1); column and phase clear.
- S_CAPT, on vs_rise:
  - Commit when row == IMG_H and the error flag is 0: set the target's full flag, pulse oFrmDone, toggle rNextSel.
  - Otherwise pulse oFrmErr; no flag change; rNextSel unchanged.
  - Either way, return to S_IDLE.
- S_DROP: no writes. On vs_rise, pulse oFrmDrop and go to S_IDLE.
- Full flags: iBufNRel clears oBufNFull on the next cycle. If set and clear coincide on the same flag, set wins. Release of the buffer being captured cannot occur, because capture only starts into an empty buffer.
- A VSYNC edge and a byte in the same cycle: process the byte first, then the edge.
- Pulses (oFrmDone/Err/Drop) are mutually exclusive and last exactly 1 cycle.
- All arithmetic is unsigned. The pixel count is ADDR_W bits and never wraps, because of the overflow guard.

Decomposition:
- Shared package cam_pkg: IMG_W, IMG_H, TOTAL_PIXELS, ADDR_W; state encoding S_IDLE=2'b00, S_CAPT=2'b01, S_DROP=2'b10. The reader uses the same constants.
- Sub-module cam_pix_pack: byte phase, high-byte latch and the 1-cycle write register (oWrEn/oWrDt). It has a clear input driven on hr_fall and on entry to S_CAPT.
- FSM, counters and flags stay in cam_buf_wr.

Test Plan:
1. Full 480x272 frame, 2 bytes/pixel, into empty buffers -> 130560 writes at addr 0..130559; first oWrDt = {byte0,byte1}; oBuf0Full=1 and one oFrmDone at vs_rise; next frame has oBufSel=1.
2. Two good frames with no release, then a third -> buffers 0 and 1 full; third frame gives zero writes, oFrmDrop pulse, flags unchanged; iBuf0Rel then a fourth frame -> written to buffer 0.
3. Line 5 carries 479 pixels -> oFrmErr at vs_rise; no flag set; the next frame reuses the same oBufSel.
4. Odd byte count on one line (phase 1 at hr_fall) -> oFrmErr; frame with 273 lines -> oFrmErr; 481st pixel on the last line -> suppressed write, oFrmErr.
5. wRst asserted mid-line 100 -> next cycle all outputs 0; the following full frame is captured into buffer 0 with oFrmDone.
6. iBuf1Rel in the same cycle that buffer 1's commit sets oBuf1Full -> oBuf1Full=1 (set wins).
